int_ctrl: RTL and testbench

Memory-mapped external interrupt controller that sits directly upstream of the coprocessor-0 block. It synchronizes six asynchronous interrupt sources and detects edges or levels per source. It holds pending state with software set/clear and drives the 6-bit interrupt vector consumed by CP0's interrupt inputs. The CPU accesses it over the data-memory bus (word-addressed, single-cycle write, combinational read).

---
 rtl/int_ctrl.sv | 94 +++++++++
 tb/tb_int_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// External interrupt controller feeding CP0: synchronizes six sources,
// latches edge/level pending state and exposes it over the data bus.
module int_ctrl #(
  parameter int          N_IRQ       = 6,
  parameter int          SYNC_STAGES = 2,
  parameter logic [5:0]  EN_RESET    = 6'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [1:0]       addr,
  input  logic             we,
  input  logic [31:0]      wd,
  output logic [31:0]      rd,
  output logic [N_IRQ-1:0] interrupt,
  output logic             irq_any
);

  localparam logic [1:0] A_PEND = 2'd0;
  localparam logic [1:0] A_EN   = 2'd1;
  localparam logic [1:0] A_MODE = 2'd2;
  localparam logic [1:0] A_SWS  = 2'd3;

  logic [SYNC_STAGES-1:0][N_IRQ-1:0] r_sync;
  logic [N_IRQ-1:0] r_s_d;
  logic [N_IRQ-1:0] r_pend;
  logic [N_IRQ-1:0] r_en;
  logic [N_IRQ-1:0] r_mode;

  logic [N_IRQ-1:0] w_s;
  logic [N_IRQ-1:0] w_rise;
  logic [N_IRQ-1:0] w_set;
  logic [N_IRQ-1:0] w_clr;
  logic [N_IRQ-1:0] w_pend_nx;
  logic [N_IRQ-1:0] w_wd;
  logic             w_unused;

  assign w_s      = r_sync[SYNC_STAGES-1];
  assign w_wd     = wd[N_IRQ-1:0];
  assign w_unused = ^wd[31:N_IRQ];
  assign w_rise   = w_s & ~r_s_d;

  always_comb begin
    w_set = w_rise;
    w_clr = '0;
    unique case (1'b1)
      (we && addr == A_SWS):  w_set = w_rise | w_wd;
      (we && addr == A_PEND): w_clr = w_wd;
      default: ;
    endcase
  end

  // Edge bits: set wins over W1C so a coincident event is never lost.
  always_comb begin
    w_pend_nx = w_s;
    for (int i = 0; i < N_IRQ; i++) begin
      if (r_mode[i]) begin
        if (w_set[i])      w_pend_nx[i] = 1'b1;
        else if (w_clr[i]) w_pend_nx[i] = 1'b0;
        else               w_pend_nx[i] = r_pend[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_s_d  <= '0;
      r_pend <= '0;
      r_mode <= '0;
      r_en   <= EN_RESET[N_IRQ-1:0];
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], irq_in};
      r_s_d  <= w_s;
      r_pend <= w_pend_nx;
      if (we && addr == A_EN)   r_en   <= w_wd;
      if (we && addr == A_MODE) r_mode <= w_wd;
    end
  end

  always_comb begin
    rd = '0;
    case (addr)
      A_PEND:  rd[N_IRQ-1:0] = r_pend;
      A_EN:    rd[N_IRQ-1:0] = r_en;
      A_MODE:  rd[N_IRQ-1:0] = r_mode;
      default: rd[N_IRQ-1:0] = w_s;
    endcase
  end

  assign interrupt = r_pend & r_en;
  assign irq_any   = |interrupt;

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: expectations are queued when stimulus
// is applied and popped when the matching output is observed.
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  irq_in;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic [5:0]  interrupt;
  logic        irq_any;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  always #5 clk = ~clk;

  int_ctrl #(.N_IRQ(6), .SYNC_STAGES(2), .EN_RESET(6'h00)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .addr(addr), .we(we),
    .wd(wd), .rd(rd), .interrupt(interrupt), .irq_any(irq_any)
  );

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; we = 1'b1; wd = d;
    @(negedge clk);
    we = 1'b0; wd = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 4; a++) exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    for (int a = 0; a < 4; a++) begin
      addr = a[1:0];
      #1;
      e = exp_q.pop_front();
      total++;
      if (rd !== e) begin
        bad++;
        $display("FAIL reset_rd%0d got=%h exp=%h", a, rd, e);
      end
    end
    e = exp_q.pop_front();
    total++;
    if (interrupt !== e[5:0] || irq_any !== 1'b0) begin
      bad++;
      $display("FAIL reset_int got=%h/%b exp=%h/0", interrupt, irq_any, e[5:0]);
    end
  endtask

  task automatic test_edge_latency;
    wr(2'd2, 32'h3F);
    wr(2'd1, 32'h01);
    irq_in = 6'h01;
    exp_q.push_back(32'h00);
    exp_q.push_back(32'h00);
    exp_q.push_back(32'h01);
    exp_q.push_back(32'h01);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      irq_in = 6'h00;
      e = exp_q.pop_front();
      total++;
      if (interrupt !== e[5:0]) begin
        bad++;
        $display("FAIL edge_lat_c%0d got=%h exp=%h", c, interrupt, e[5:0]);
      end
    end
    exp_q.push_back(32'h00);
    wr(2'd0, 32'h01);
    e = exp_q.pop_front();
    total++;
    if (interrupt !== e[5:0]) begin
      bad++;
      $display("FAIL edge_w1c got=%h exp=%h", interrupt, e[5:0]);
    end
  endtask

  task automatic test_collision;
    wr(2'd1, 32'h08);
    irq_in = 6'h08;
    @(negedge clk);
    @(negedge clk);
    addr = 2'd0; we = 1'b1; wd = 32'h08;
    exp_q.push_back(32'h08);
    exp_q.push_back(32'h08);
    @(negedge clk);
    we = 1'b0; wd = '0; irq_in = 6'h00;
    #1;
    e = exp_q.pop_front();
    total++;
    if (interrupt !== e[5:0]) begin
      bad++;
      $display("FAIL collide_int got=%h exp=%h", interrupt, e[5:0]);
    end
    e = exp_q.pop_front();
    total++;
    if (rd !== e) begin
      bad++;
      $display("FAIL collide_pend got=%h exp=%h", rd, e);
    end
    exp_q.push_back(32'h00);
    wr(2'd0, 32'h08);
    e = exp_q.pop_front();
    total++;
    if (interrupt !== e[5:0]) begin
      bad++;
      $display("FAIL collide_clr got=%h exp=%h", interrupt, e[5:0]);
    end
  endtask

  task automatic test_level;
    wr(2'd2, 32'h00);
    wr(2'd1, 32'h20);
    irq_in = 6'h20;
    exp_q.push_back(32'h00);
    exp_q.push_back(32'h00);
    exp_q.push_back(32'h20);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (interrupt !== e[5:0]) begin
        bad++;
        $display("FAIL level_rise_c%0d got=%h exp=%h", c, interrupt, e[5:0]);
      end
    end
    exp_q.push_back(32'h20);
    addr = 2'd3;
    #1;
    e = exp_q.pop_front();
    total++;
    if (rd !== e) begin
      bad++;
      $display("FAIL level_sync_rd got=%h exp=%h", rd, e);
    end
    exp_q.push_back(32'h20);
    wr(2'd0, 32'h20);
    e = exp_q.pop_front();
    total++;
    if (interrupt !== e[5:0]) begin
      bad++;
      $display("FAIL level_w1c got=%h exp=%h", interrupt, e[5:0]);
    end
    irq_in = 6'h00;
    exp_q.push_back(32'h20);
    exp_q.push_back(32'h20);
    exp_q.push_back(32'h00);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (interrupt !== e[5:0]) begin
        bad++;
        $display("FAIL level_fall_c%0d got=%h exp=%h", c, interrupt, e[5:0]);
      end
    end
  endtask

  task automatic test_mask_swset;
    wr(2'd1, 32'h00);
    wr(2'd2, 32'h3F);
    wr(2'd3, 32'hFFFF_FF12);
    exp_q.push_back(32'h12);
    addr = 2'd0;
    #1;
    e = exp_q.pop_front();
    total++;
    if (rd !== e) begin
      bad++;
      $display("FAIL swset_pend got=%h exp=%h", rd, e);
    end
    exp_q.push_back(32'h00);
    e = exp_q.pop_front();
    total++;
    if (interrupt !== e[5:0] || irq_any !== 1'b0) begin
      bad++;
      $display("FAIL swset_masked got=%h/%b exp=%h/0", interrupt, irq_any, e[5:0]);
    end
    exp_q.push_back(32'h10);
    wr(2'd1, 32'h10);
    e = exp_q.pop_front();
    total++;
    if (interrupt !== e[5:0] || irq_any !== 1'b1) begin
      bad++;
      $display("FAIL swset_unmask got=%h/%b exp=%h/1", interrupt, irq_any, e[5:0]);
    end
  endtask

  task automatic test_reset_mid;
    wr(2'd1, 32'h3F);
    wr(2'd3, 32'h3F);
    exp_q.push_back(32'h3F);
    e = exp_q.pop_front();
    total++;
    if (interrupt !== e[5:0]) begin
      bad++;
      $display("FAIL rstmid_pre got=%h exp=%h", interrupt, e[5:0]);
    end
    rst = 1'b1; addr = 2'd3; we = 1'b1; wd = 32'h3F;
    exp_q.push_back(32'h00);
    exp_q.push_back(32'h00);
    exp_q.push_back(32'h00);
    exp_q.push_back(32'h00);
    @(negedge clk);
    rst = 1'b0; we = 1'b0; wd = '0;
    e = exp_q.pop_front();
    total++;
    if (interrupt !== e[5:0] || irq_any !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_int got=%h exp=%h", interrupt, e[5:0]);
    end
    for (int a = 0; a < 3; a++) begin
      addr = a[1:0];
      #1;
      e = exp_q.pop_front();
      total++;
      if (rd !== e) begin
        bad++;
        $display("FAIL rstmid_rd%0d got=%h exp=%h", a, rd, e);
      end
    end
  endtask

  initial begin
    rst = 1'b1; irq_in = '0; addr = '0; we = 1'b0; wd = '0;
    test_reset();
    test_edge_latency();
    test_collision();
    test_level();
    test_mask_swset();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
